decode_stage: RTL and testbench

// Instruction-decode pipeline stage; produces the 4-bit ALU control code and operand selects consumed by execute.

---
 rtl/decode_stage_pkg.sv | 45 ++++
 rtl/decode_rom.sv | 30 +++
 rtl/decode_stage.sv | 153 +++++++++++++++
 tb/tb_decode_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared decode constants: instruction field positions, ALU control codes, the
// decode-ROM output bundle and the decode FSM state encoding. The execute-stage
// ALU imports the same ALU_* codes.
package decode_stage_pkg;

  // Instruction word fields
  localparam int unsigned OP_MSB   = 15;
  localparam int unsigned OP_LSB   = 11;
  localparam int unsigned RSRC_MSB = 10;
  localparam int unsigned RSRC_LSB = 8;
  localparam int unsigned RDST_MSB = 7;
  localparam int unsigned RDST_LSB = 5;

  // Opcodes at or above this value are illegal and decode as a NOP bubble
  localparam logic [4:0] OP_ILLEGAL_MIN = 5'd15;

  // ALU control codes
  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_NOT  = 4'd1;
  localparam logic [3:0] ALU_INC  = 4'd2;
  localparam logic [3:0] ALU_DEC  = 4'd3;
  localparam logic [3:0] ALU_MOV  = 4'd4;
  localparam logic [3:0] ALU_ADD  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_SHL  = 4'd9;
  localparam logic [3:0] ALU_SHR  = 4'd10;
  localparam logic [3:0] ALU_SETC = 4'd11;
  localparam logic [3:0] ALU_CLRC = 4'd12;
  localparam logic [3:0] ALU_LDD  = 4'd13;
  localparam logic [3:0] ALU_STD  = 4'd14;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       reg_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic       two_word;
  } rom_out_t;

  // StOp: expecting an instruction word; StImm: expecting the trailing immediate
  typedef enum logic {StOp, StImm} state_e;

endpackage

// File: rtl/decode_rom.sv
// Pure combinational opcode decoder.
// Ports:
//   op   in  5-bit opcode field
//   ctrl out {alu_op, reg_wr, mem_rd, mem_wr, two_word}
module decode_rom
  import decode_stage_pkg::*;
(
  input  logic [4:0] op,
  output rom_out_t   ctrl
);

  always_comb begin
    ctrl = '0;
    if (op < OP_ILLEGAL_MIN) begin
      ctrl.alu_op = op[3:0];
      case (op[3:0])
        ALU_NOT, ALU_INC, ALU_DEC, ALU_MOV, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
        ALU_SHL, ALU_SHR, ALU_LDD: ctrl.reg_wr = 1'b1;
        default:                   ctrl.reg_wr = 1'b0;
      endcase
      ctrl.mem_rd = (op[3:0] == ALU_LDD);
      ctrl.mem_wr = (op[3:0] == ALU_STD);
      case (op[3:0])
        ALU_SHL, ALU_SHR, ALU_LDD, ALU_STD: ctrl.two_word = 1'b1;
        default:                            ctrl.two_word = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode pipeline stage. Takes 16-bit words from fetch, pairs
// two-word instructions with their trailing immediate, and presents a registered
// ID/EX bundle to execute under a valid/ready handshake with stall and flush.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_instr    fetch word; in_ready = stage accepts it this cycle
//   flush                 squash bundle and any half-received instruction
//   out_ready             execute accepts bundle (0 = stall)
//   out_valid, out_alu_op, out_rsrc, out_rdst, out_imm,
//   out_reg_wr, out_mem_rd, out_mem_wr   registered ID/EX bundle
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned N    = 16,
  parameter int unsigned RA_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [N-1:0]    in_instr,
  output logic            in_ready,
  input  logic            flush,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [3:0]      out_alu_op,
  output logic [RA_W-1:0] out_rsrc,
  output logic [RA_W-1:0] out_rdst,
  output logic [N-1:0]    out_imm,
  output logic            out_reg_wr,
  output logic            out_mem_rd,
  output logic            out_mem_wr
);

  state_e          state_q, state_d;
  rom_out_t        rom_ctrl;
  rom_out_t        held_ctrl_q, held_ctrl_d;
  logic [RA_W-1:0] held_rsrc_q, held_rsrc_d;
  logic [RA_W-1:0] held_rdst_q, held_rdst_d;

  logic            valid_q, valid_d;
  logic [3:0]      alu_q, alu_d;
  logic [RA_W-1:0] rsrc_q, rsrc_d;
  logic [RA_W-1:0] rdst_q, rdst_d;
  logic [N-1:0]    imm_q, imm_d;
  logic            reg_wr_q, reg_wr_d;
  logic            mem_rd_q, mem_rd_d;
  logic            mem_wr_q, mem_wr_d;
  logic            accept;

  decode_rom u_decode_rom (
    .op   (in_instr[OP_MSB:OP_LSB]),
    .ctrl (rom_ctrl)
  );

  assign in_ready = (!valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    held_ctrl_d = held_ctrl_q;
    held_rsrc_d = held_rsrc_q;
    held_rdst_d = held_rdst_q;
    valid_d     = valid_q;
    alu_d       = alu_q;
    rsrc_d      = rsrc_q;
    rdst_d      = rdst_q;
    imm_d       = imm_q;
    reg_wr_d    = reg_wr_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;

    if (flush) begin
      valid_d     = 1'b0;
      state_d     = StOp;
      held_ctrl_d = '0;
    end else begin
      // Bundle consumed; a load below may replace it in the same cycle
      if (valid_q && out_ready) valid_d = 1'b0;
      if (accept) begin
        unique case (state_q)
          StOp: begin
            if (rom_ctrl.two_word) begin
              held_ctrl_d = rom_ctrl;
              held_rsrc_d = in_instr[RSRC_MSB:RSRC_LSB];
              held_rdst_d = in_instr[RDST_MSB:RDST_LSB];
              state_d     = StImm;
            end else begin
              valid_d  = 1'b1;
              alu_d    = rom_ctrl.alu_op;
              rsrc_d   = in_instr[RSRC_MSB:RSRC_LSB];
              rdst_d   = in_instr[RDST_MSB:RDST_LSB];
              imm_d    = '0;
              reg_wr_d = rom_ctrl.reg_wr;
              mem_rd_d = rom_ctrl.mem_rd;
              mem_wr_d = rom_ctrl.mem_wr;
            end
          end
          StImm: begin
            valid_d  = 1'b1;
            alu_d    = held_ctrl_q.alu_op;
            rsrc_d   = held_rsrc_q;
            rdst_d   = held_rdst_q;
            imm_d    = in_instr;
            reg_wr_d = held_ctrl_q.reg_wr;
            mem_rd_d = held_ctrl_q.mem_rd;
            mem_wr_d = held_ctrl_q.mem_wr;
            state_d  = StOp;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StOp;
      held_ctrl_q <= '0;
      held_rsrc_q <= '0;
      held_rdst_q <= '0;
      valid_q     <= 1'b0;
      alu_q       <= ALU_NOP;
      rsrc_q      <= '0;
      rdst_q      <= '0;
      imm_q       <= '0;
      reg_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      held_ctrl_q <= held_ctrl_d;
      held_rsrc_q <= held_rsrc_d;
      held_rdst_q <= held_rdst_d;
      valid_q     <= valid_d;
      alu_q       <= alu_d;
      rsrc_q      <= rsrc_d;
      rdst_q      <= rdst_d;
      imm_q       <= imm_d;
      reg_wr_q    <= reg_wr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_alu_op = alu_q;
  assign out_rsrc   = rsrc_q;
  assign out_rdst   = rdst_q;
  assign out_imm    = imm_q;
  assign out_reg_wr = reg_wr_q;
  assign out_mem_rd = mem_rd_q;
  assign out_mem_wr = mem_wr_q;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  out_alu_op;
  logic [2:0]  out_rsrc;
  logic [2:0]  out_rdst;
  logic [15:0] out_imm;
  logic        out_reg_wr;
  logic        out_mem_rd;
  logic        out_mem_wr;

  int vectors;
  int miscompares;

  // Reference model: expected bundle plus "waiting for immediate" with the raw first word
  bit          e_valid;
  int unsigned e_alu, e_rsrc, e_rdst, e_imm;
  bit          e_rw, e_mr, e_mw;
  bit          m_wait_imm;
  logic [15:0] m_first;

  decode_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_alu_op (out_alu_op),
    .out_rsrc   (out_rsrc),
    .out_rdst   (out_rdst),
    .out_imm    (out_imm),
    .out_reg_wr (out_reg_wr),
    .out_mem_rd (out_mem_rd),
    .out_mem_wr (out_mem_wr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_two_word(input logic [15:0] w);
    int unsigned op;
    op = w / 2048;
    return (op == 9) || (op == 10) || (op == 13) || (op == 14);
  endfunction

  task automatic model_load(input logic [15:0] w, input logic [15:0] imm);
    int unsigned op;
    bit legal;
    op      = w / 2048;
    legal   = op < 15;
    e_valid = 1'b1;
    e_alu   = legal ? op : 0;
    e_rsrc  = (w / 256) % 8;
    e_rdst  = (w / 32) % 8;
    e_imm   = imm;
    e_rw    = legal && ((op >= 1 && op <= 10) || op == 13);
    e_mr    = (op == 13);
    e_mw    = (op == 14);
  endtask

  task automatic model_reset();
    e_valid = 0; e_alu = 0; e_rsrc = 0; e_rdst = 0; e_imm = 0;
    e_rw = 0; e_mr = 0; e_mw = 0;
    m_wait_imm = 0; m_first = '0;
  endtask

  function automatic bit model_ready();
    return (!e_valid || out_ready) && !flush;
  endfunction

  task automatic model_step();
    bit acc;
    acc = in_valid && model_ready();
    if (flush) begin
      e_valid    = 0;
      m_wait_imm = 0;
    end else begin
      if (e_valid && out_ready) e_valid = 0;
      if (acc) begin
        if (m_wait_imm) begin
          model_load(m_first, in_instr);
          m_wait_imm = 0;
        end else if (is_two_word(in_instr)) begin
          m_first    = in_instr;
          m_wait_imm = 1;
        end else begin
          model_load(in_instr, 16'h0000);
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"},  32'(out_valid),  32'(e_valid));
    check({tag, ".alu_op"}, 32'(out_alu_op), e_alu);
    check({tag, ".rsrc"},   32'(out_rsrc),   e_rsrc);
    check({tag, ".rdst"},   32'(out_rdst),   e_rdst);
    check({tag, ".imm"},    32'(out_imm),    e_imm);
    check({tag, ".reg_wr"}, 32'(out_reg_wr), 32'(e_rw));
    check({tag, ".mem_rd"}, 32'(out_mem_rd), 32'(e_mr));
    check({tag, ".mem_wr"}, 32'(out_mem_wr), 32'(e_mw));
  endtask

  // Drive inputs, check in_ready, clock once, check the bundle
  task automatic cycle(input string tag, input bit v, input logic [15:0] w, input bit r,
                       input bit f);
    in_valid  = v;
    in_instr  = w;
    out_ready = r;
    flush     = f;
    #1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(model_ready()));
    model_step();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #12;
    check_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD: one-cycle latency, alu_op 5, rsrc 1, rdst 1, reg_wr
    cycle("add", 1, 16'h2920, 1, 0);
    check("add.alu_lit", 32'(out_alu_op), 32'd5);
    cycle("idle", 0, 16'h0000, 1, 0);

    // SHL + immediate 3
    cycle("shl_w1", 1, 16'h4A40, 1, 0);
    cycle("shl_imm", 1, 16'h0003, 1, 0);
    check("shl.imm_lit", 32'(out_imm), 32'd3);

    // Back-to-back one-word ops, then a stall for 3 cycles with a word waiting
    cycle("b2b0", 1, 16'h0800, 1, 0);
    cycle("b2b1", 1, 16'h1100, 1, 0);
    cycle("stall_add", 1, 16'h2920, 0, 0);
    cycle("stall1", 1, 16'h3000, 0, 0);
    cycle("stall2", 1, 16'h3000, 0, 0);
    cycle("stall3", 1, 16'h3000, 1, 0);

    // LDD first word then flush; NOT r0 afterwards
    cycle("ldd_w1", 1, 16'h6A20, 1, 0);
    cycle("flush", 1, 16'h1234, 1, 1);
    cycle("not_r0", 1, 16'h0800, 1, 0);
    check("not.alu_lit", 32'(out_alu_op), 32'd1);

    // Illegal opcode: NOP bubble, still valid
    cycle("illegal", 1, 16'hF800, 1, 0);
    cycle("stdimm_w1", 1, 16'h7100, 1, 0);
    cycle("stdimm_w2", 1, 16'hBEEF, 1, 0);

    // Async reset in the middle of a two-word instruction
    cycle("pre_rst_add", 1, 16'h2920, 1, 0);
    cycle("pre_rst_shr", 1, 16'h5240, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    #2;
    rst_n = 1'b1;
    cycle("post_rst_word", 1, 16'h0003, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 3) == 0) w[15:11] = 5'(9 + 4 * $urandom_range(0, 1));
      cycle("rand", ($urandom_range(0, 9) < 7), w, ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
